// File: rtl/gr8b0nd_data_mem_responder_pkg.sv
// rtl/gr8b0nd_data_mem_responder_pkg.sv - shared types and constants for the data-memory responder
package gr8b0nd_data_mem_responder_pkg;

    typedef logic [15:0] word_t;

    localparam logic [7:0] OP_LD = 8'h40;
    localparam logic [7:0] OP_ST = 8'h41;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int LATENCY_W = 4;

endpackage

// File: rtl/gr8b0nd_sp_ram.sv
// rtl/gr8b0nd_sp_ram.sv - single-port synchronous word RAM with registered read
module gr8b0nd_sp_ram
    import gr8b0nd_data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];

    // Contents are deliberately never reset so data survives a responder reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

    task automatic preload(input logic [AW-1:0] a, input word_t d);
        mem[a] <= d;
    endtask

endmodule

// File: rtl/gr8b0nd_data_mem_responder.sv
// rtl/gr8b0nd_data_mem_responder.sv - fixed-latency load/store responder for the core data memory
module gr8b0nd_data_mem_responder
    import gr8b0nd_data_mem_responder_pkg::*;
#(
    parameter int          DEPTH      = 65536,
    parameter int          LATENCY    = 2,
    parameter logic [15:0] INIT_ADDR0 = 16'd420
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]           state;
    logic [LATENCY_W-1:0] cnt;
    logic                 we_q;
    word_t                addr_q;
    word_t                wdata_q;
    logic                 err_q;

    logic                 commit;
    word_t                cur_addr;
    logic                 cur_we;
    word_t                cur_wdata;
    logic                 in_rng;
    word_t                ram_rdata;

    // With LATENCY=1 the accepting edge is also the commit edge, so the live
    // inputs feed the RAM directly; otherwise the latched copy does.
    always_comb begin
        cur_addr  = addr_q;
        cur_we    = we_q;
        cur_wdata = wdata_q;
        if (state == S_IDLE) begin
            cur_addr  = addr;
            cur_we    = we;
            cur_wdata = wdata;
        end
        commit = ((state == S_IDLE) && req && (LATENCY == 1)) ||
                 ((state == S_WAIT) && (cnt <= LATENCY_W'(1)));
        in_rng = ({1'b0, cur_addr} < 17'(DEPTH));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= commit && !in_rng;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= LATENCY_W'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt <= LATENCY_W'(1)) begin
                        cnt   <= '0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - LATENCY_W'(1);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with reset keeps a held request from writing while in reset.
    gr8b0nd_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (commit && in_rng && reset),
        .we    (cur_we),
        .addr  (cur_addr[AW-1:0]),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    assign ack   = (state == S_RESP);
    assign busy  = (state != S_IDLE);
    assign err   = ack && err_q;
    assign rdata = (ack && !err_q) ? (we_q ? wdata_q : ram_rdata) : 16'h0000;

    task automatic preload_init();
        u_ram.preload('0, INIT_ADDR0);
    endtask

endmodule

// File: tb/tb_gr8b0nd_data_mem_responder.sv
// tb/tb_gr8b0nd_data_mem_responder.sv - randomized self-checking bench for the data-memory responder
module tb_gr8b0nd_data_mem_responder;

    localparam int LAT [3] = '{2, 1, 4};
    localparam int DEP [3] = '{65536, 1024, 1024};

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic        we    [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic        ack   [3];
    logic [15:0] rdata [3];
    logic        err   [3];
    logic        busy  [3];

    logic [15:0] mm [3][1024];
    int          n_err = 0;
    int          n_chk = 0;
    int          g;

    always #5 clk = ~clk;

    gr8b0nd_data_mem_responder #(.DEPTH(65536), .LATENCY(2), .INIT_ADDR0(16'd420)) u_dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));
    gr8b0nd_data_mem_responder #(.DEPTH(1024), .LATENCY(1), .INIT_ADDR0(16'd420)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));
    gr8b0nd_data_mem_responder #(.DEPTH(1024), .LATENCY(4), .INIT_ADDR0(16'd420)) u_dut2 (
        .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction on instance i; entered and left at #1 after a rising edge.
    task automatic txn(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit drop, input bit scramble, output int gap);
        logic [15:0] exp_rd;
        bit          exp_err;
        bit          ok;
        int          n;
        if (int'(a) >= DEP[i]) begin
            exp_err = 1'b1;
            exp_rd  = 16'h0;
        end else if (w) begin
            exp_err = 1'b0;
            exp_rd  = d;
            mm[i][a[9:0]] = d;
        end else begin
            exp_err = 1'b0;
            exp_rd  = mm[i][a[9:0]];
        end
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        gap = 0;
        ok  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            gap++;
            if (busy[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 32'(ok), 32'd1);
        if (!ok) begin
            req[i] = 1'b0;
            return;
        end
        n = 1;
        while (!ack[i] && n < 20) begin
            chk("busy_wait", 32'(busy[i]), 32'd1);
            if (scramble) begin
                addr[i]  = 16'($urandom);
                wdata[i] = 16'($urandom);
                we[i]    = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(LAT[i]));
        chk("ack", 32'(ack[i]), 32'd1);
        chk("rdata", 32'(rdata[i]), 32'(exp_rd));
        chk("err", 32'(err[i]), 32'(exp_err));
        if (drop) req[i] = 1'b0;
        @(posedge clk); #1;
        chk("ack_pulse", 32'(ack[i]), 32'd0);
        chk("idle_busy", 32'(busy[i]), 32'd0);
        chk("idle_rdata", 32'(rdata[i]), 32'd0);
        chk("idle_err", 32'(err[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] a;
        bit          w;
        bit          dr;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        #1;
        for (int k = 0; k < 1024; k++) begin
            d = 16'($urandom); u_dut0.u_ram.preload(16'(k), d); mm[0][k] = d;
            d = 16'($urandom); u_dut1.u_ram.preload(10'(k), d); mm[1][k] = d;
            d = 16'($urandom); u_dut2.u_ram.preload(10'(k), d); mm[2][k] = d;
        end
        u_dut0.preload_init();
        mm[0][0] = 16'd420;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ack", 32'(ack[i]), 32'd0);
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_rdata", 32'(rdata[i]), 32'd0);
            chk("reset_err", 32'(err[i]), 32'd0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        txn(0, 1'b0, 16'd0, 16'h0, 1'b1, 1'b0, g);
        chk("init_word0", 32'(mm[0][0]), 32'd420);

        txn(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, g);
        txn(0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, g);
        chk("b2b_gap", 32'(g), 32'd1);

        txn(1, 1'b0, 16'd1024, 16'h0, 1'b1, 1'b0, g);
        txn(1, 1'b1, 16'd2000, 16'h5555, 1'b1, 1'b0, g);
        txn(1, 1'b0, 16'd976, 16'h0, 1'b1, 1'b0, g);

        for (int r = 0; r < 6; r++) begin
            txn(1, 1'b0, 16'd5, 16'h0, (r == 5), 1'b0, g);
            if (r > 0) chk("lat1_gap", 32'(g), 32'd1);
        end

        txn(2, 1'b1, 16'd100, 16'($urandom), 1'b1, 1'b1, g);
        txn(2, 1'b0, 16'd100, 16'h0, 1'b1, 1'b1, g);

        txn(2, 1'b1, 16'd7, 16'h1234, 1'b1, 1'b0, g);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'd7; wdata[2] = 16'hABCD;
        @(posedge clk); #1;
        chk("rst_accept", 32'(busy[2]), 32'd1);
        req[2] = 1'b0;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("rst_async_ack", 32'(ack[2]), 32'd0);
        chk("rst_async_busy", 32'(busy[2]), 32'd0);
        chk("rst_async_rdata", 32'(rdata[2]), 32'd0);
        chk("rst_async_err", 32'(err[2]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_late_ack", 32'(ack[2]), 32'd0);
        txn(2, 1'b0, 16'd7, 16'h0, 1'b1, 1'b0, g);
        chk("rst_store_dropped", 32'(mm[2][7]), 32'h1234);

        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 30; t++) begin
                w = 1'($urandom);
                if (DEP[i] < 65536 && $urandom_range(0, 7) == 0)
                    a = 16'($urandom_range(1024, 65535));
                else
                    a = 16'($urandom_range(0, 1023));
                dr = (t == 29) ? 1'b1 : 1'($urandom);
                txn(i, w, a, 16'($urandom), dr, 1'($urandom), g);
                if (dr) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gr8b0nd_data_mem_responder.md
Name: gr8b0nd_data_mem_responder

Overview:
Responder side of the processor's data-memory interface. It services the load (OPld 8'h40) and store (OPst 8'h41) requests that the multicycle core issues, over a req/ack handshake with fixed, parameterised latency. It holds a word-addressed 16-bit data RAM and performs the range check that makes the core halt. It sits between the core's ExecuteGeneral state and the data storage, replacing the core-internal data array.

Parameters:
DEPTH, 65536, number of 16-bit words implemented; legal addresses are 0..DEPTH-1.
LATENCY, 2, clock edges from request acceptance to ack; legal range 1..15.
INIT_ADDR0, 16'd420, value loaded into word 0 by the bench preload task. Not applied on reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
req  input  1  initiator request; held with addr/we/wdata stable until ack is sampled
we  input  1  1 = store, 0 = load
addr  input  16  word address (register[rs] from the core)
wdata  input  16  store data (register[rd] from the core)
ack  output  1  one-cycle completion pulse
rdata  output  16  load data; valid only while ack=1
err  output  1  out-of-range flag; valid only while ack=1; the core raises halt on it
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, err=0, rdata=0, busy=0, counter=0, latched request cleared. RAM contents are retained and never cleared.
- Reset mid-operation: the pending transaction is dropped. A store that has not yet reached its commit edge is not written. No ack is issued for it.
- FSM states:
  - IDLE: on a rising edge with req=1, latch addr/we/wdata, set counter=LATENCY-1, busy=1.
    - If LATENCY=1, go to RESP.
    - Otherwise, go to WAIT.
  - WAIT: decrement the counter each edge. Go to RESP on the edge where the counter reaches 1.
  - RESP: ack=1 for exactly one cycle. Always go to IDLE next edge.
- Commit edge: the edge that enters RESP. At this edge:
  - rdata and err are registered.
  - A store is written to RAM.
- Timing: a request accepted at edge E0 gives ack=1 in the cycle after edge E0+LATENCY-1. The initiator samples ack at edge E0+LATENCY.
- Inputs are latched at acceptance. Changes to addr/we/wdata/req while busy are ignored.
- Out of range (latched addr >= DEPTH): err=1, rdata=0, no RAM write.
- In range:
  - Load: rdata=RAM[addr], err=0.
  - Store: RAM[addr]<=wdata, rdata=wdata (echo), err=0.
- Outside RESP: ack=0, err=0, rdata=0.
- Back-to-back: if req is still 1 in the IDLE cycle after RESP, it is a new request. An initiator that does not want a repeat must drop req on the edge at which it samples ack.
- Read-after-write to the same address in consecutive transactions returns the new data.
- A req that rises while busy is not accepted until IDLE.

Decomposition:
- Shared package/include holds:
  - WORDSIZE 15:0
  - OPld/OPst opcode constants
  - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2
  - a LATENCY_W=4 constant for the counter width
- One natural sub-module: gr8b0nd_sp_ram. It is a single-port synchronous RAM (DEPTH x 16) with write-enable, registered read, and a bench-only preload task. It keeps storage separate from the handshake FSM.

Test Plan:
- Reset with LATENCY=2; preload word 0 = 420; load addr 0 -> ack once, 2 edges after acceptance; rdata=16'd420, err=0; busy high for 2 cycles.
- Store addr 16'h0010 data 16'hBEEF, then immediate back-to-back load of 16'h0010 -> store ack with rdata=16'hBEEF; load ack with rdata=16'hBEEF; no idle gap beyond one IDLE cycle.
- DEPTH=1024: load addr 16'd1024 -> ack with err=1, rdata=0. Store to 16'd2000 -> err=1, and RAM[2000 mod 1024] remains unchanged.
- LATENCY=1: hold req high continuously with a load of addr 5 -> ack on every other cycle (IDLE/RESP alternation), each with the same rdata.
- Change addr and wdata while busy (LATENCY=4) -> response reflects the originally latched values only.
- Assert reset=0 during WAIT of a store to addr 7 (old value 16'h1234) -> no ack; outputs 0 immediately (asynchronously); after release, a load of addr 7 returns 16'h1234.
